// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute-stage ALU result and a word-wide data memory.
// Latency: fault 1, load/sw 2, sb/sh 3 cycles from acceptance to resp_valid.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready, is_store, funct3, addr, store_data : request side
//   resp_valid, load_data, misaligned, illegal              : one-cycle response
//   mem_addr, mem_wdata, mem_we, mem_rdata                  : word memory, rdata combinational
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic        r_is_store;
  logic [31:0] r_sdata;
  logic [31:0] r_wdata;
  logic [31:0] r_load_data;
  logic        r_misaligned;
  logic        r_illegal;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_mem_we;

  logic        w_legal;
  logic        w_mis;
  logic        w_fault;
  logic        w_need_rd;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_ext;
  logic [31:0] w_merge;

  // Decode of the incoming request (only used in IDLE).
  always_comb begin
    w_legal = 1'b0;
    if (is_store) begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      w_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b101);
    end
  end

  always_comb begin
    w_mis = 1'b0;
    case (funct3[1:0])
      2'b01:   w_mis = addr[0];
      2'b10:   w_mis = |addr[1:0];
      default: w_mis = 1'b0;
    endcase
  end

  assign w_fault   = !w_legal || w_mis;
  // Everything except a full-word store needs the current memory word first.
  assign w_need_rd = !is_store || (funct3[1:0] != 2'b10);

  // Lane extraction from the read word, addressed by the captured request.
  assign w_rbyte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_rhalf = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_ext = 32'h0;
    case (r_funct3)
      3'b000:  w_ext = {{24{w_rbyte[7]}}, w_rbyte};
      3'b001:  w_ext = {{16{w_rhalf[15]}}, w_rhalf};
      3'b010:  w_ext = mem_rdata;
      3'b100:  w_ext = {24'h0, w_rbyte};
      3'b101:  w_ext = {16'h0, w_rhalf};
      default: w_ext = 32'h0;
    endcase
  end

  // Sub-word store: overwrite the addressed lane, keep the rest of the read word.
  always_comb begin
    w_merge = mem_rdata;
    if (r_funct3[1:0] == 2'b00) begin
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_sdata[7:0];
    end else if (r_funct3[1:0] == 2'b01) begin
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_sdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_addr       <= 32'h0;
      r_funct3     <= 3'h0;
      r_is_store   <= 1'b0;
      r_sdata      <= 32'h0;
      r_wdata      <= 32'h0;
      r_load_data  <= 32'h0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_mem_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= addr;
            r_funct3    <= funct3;
            r_is_store  <= is_store;
            r_sdata     <= store_data;
            r_req_ready <= 1'b0;
            if (w_fault) begin
              // Illegal takes precedence; alignment is meaningless for a bad width.
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_load_data  <= 32'h0;
              r_illegal    <= !w_legal;
              r_misaligned <= w_legal && w_mis;
            end else if (w_need_rd) begin
              r_state <= RD;
            end else begin
              r_state  <= WR;
              r_wdata  <= store_data;
              r_mem_we <= 1'b1;
            end
          end
        end
        RD: begin
          if (r_is_store) begin
            r_state  <= WR;
            r_wdata  <= w_merge;
            r_mem_we <= 1'b1;
          end else begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_load_data  <= w_ext;
            r_misaligned <= 1'b0;
            r_illegal    <= 1'b0;
          end
        end
        WR: begin
          r_state      <= RESP;
          r_mem_we     <= 1'b0;
          r_resp_valid <= 1'b1;
          r_load_data  <= 32'h0;
          r_misaligned <= 1'b0;
          r_illegal    <= 1'b0;
        end
        RESP: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign load_data  = r_load_data;
  assign misaligned = r_misaligned;
  assign illegal    = r_illegal;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .resp_valid (resp_valid),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory model: combinational read, write committed at the clock edge.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;
  int          wr_cnt;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_dat;
      wr_cnt       <= 0;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_cnt             <= wr_cnt + 1;
    end
  end

  int n_total;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request from IDLE (caller sits #1 after an edge) and follow it to resp_valid.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, output int lat, output int we_n,
                         output logic [31:0] wd);
    req_valid  = 1'b1;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat  = 1;
    we_n = 0;
    wd   = 32'h0;
    while (!resp_valid && lat < 10) begin
      if (mem_we) begin
        we_n++;
        wd = mem_wdata;
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    int          lat;
    logic [31:0] ld;
    logic        mis;
    logic        ill;
    int          we;
    logic [31:0] wd;
  } vec_t;

  vec_t tv [20];

  initial begin
    int          lat;
    int          we_n;
    int          w0;
    logic [31:0] wd;

    n_total    = 0;
    n_bad      = 0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    pre_we     = 1'b1;
    pre_idx    = 8'd64;
    pre_dat    = 32'hDEADBEEF;

    //          st    f3      addr          sdata         lat ld            mis   ill   we wd
    tv[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b0, 0, 32'h0};
    tv[1]  = '{1'b0, 3'b000, 32'h101, 32'h0,        2, 32'hFFFFFFBE, 1'b0, 1'b0, 0, 32'h0};
    tv[2]  = '{1'b0, 3'b100, 32'h101, 32'h0,        2, 32'h000000BE, 1'b0, 1'b0, 0, 32'h0};
    tv[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        2, 32'hFFFFDEAD, 1'b0, 1'b0, 0, 32'h0};
    tv[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,        2, 32'h0000BEEF, 1'b0, 1'b0, 0, 32'h0};
    tv[5]  = '{1'b0, 3'b001, 32'h100, 32'h0,        2, 32'hFFFFBEEF, 1'b0, 1'b0, 0, 32'h0};
    tv[6]  = '{1'b0, 3'b000, 32'h100, 32'h0,        2, 32'hFFFFFFEF, 1'b0, 1'b0, 0, 32'h0};
    tv[7]  = '{1'b1, 3'b001, 32'h101, 32'h5555,     1, 32'h0,        1'b1, 1'b0, 0, 32'h0};
    tv[8]  = '{1'b1, 3'b100, 32'h100, 32'h5555,     1, 32'h0,        1'b0, 1'b1, 0, 32'h0};
    tv[9]  = '{1'b0, 3'b010, 32'h102, 32'h0,        1, 32'h0,        1'b1, 1'b0, 0, 32'h0};
    tv[10] = '{1'b0, 3'b110, 32'h101, 32'h0,        1, 32'h0,        1'b0, 1'b1, 0, 32'h0};
    tv[11] = '{1'b1, 3'b000, 32'h103, 32'h12345678, 3, 32'h0,        1'b0, 1'b0, 1, 32'h78ADBEEF};
    tv[12] = '{1'b0, 3'b010, 32'h100, 32'h0,        2, 32'h78ADBEEF, 1'b0, 1'b0, 0, 32'h0};
    tv[13] = '{1'b1, 3'b001, 32'h102, 32'h0000CAFE, 3, 32'h0,        1'b0, 1'b0, 1, 32'hCAFEBEEF};
    tv[14] = '{1'b0, 3'b010, 32'h100, 32'h0,        2, 32'hCAFEBEEF, 1'b0, 1'b0, 0, 32'h0};
    tv[15] = '{1'b1, 3'b010, 32'h104, 32'h11223344, 2, 32'h0,        1'b0, 1'b0, 1, 32'h11223344};
    tv[16] = '{1'b0, 3'b010, 32'h104, 32'h0,        2, 32'h11223344, 1'b0, 1'b0, 0, 32'h0};
    tv[17] = '{1'b0, 3'b000, 32'h107, 32'h0,        2, 32'h00000011, 1'b0, 1'b0, 0, 32'h0};
    tv[18] = '{1'b0, 3'b001, 32'h106, 32'h0,        2, 32'h00001122, 1'b0, 1'b0, 0, 32'h0};
    tv[19] = '{1'b0, 3'b000, 32'h103, 32'h0,        2, 32'hFFFFFFCA, 1'b0, 1'b0, 0, 32'h0};

    // Reset with memory preload.
    repeat (3) @(posedge clk);
    #1;
    pre_we = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_resp", {31'h0, resp_valid}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_ld", load_data, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      run_req(tv[i].st, tv[i].f3, tv[i].a, tv[i].sd, lat, we_n, wd);
      chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
      chk($sformatf("v%0d_ld", i), load_data, tv[i].ld);
      chk($sformatf("v%0d_mis", i), {31'h0, misaligned}, {31'h0, tv[i].mis});
      chk($sformatf("v%0d_ill", i), {31'h0, illegal}, {31'h0, tv[i].ill});
      chk($sformatf("v%0d_wecnt", i), we_n, tv[i].we);
      chk($sformatf("v%0d_wdata", i), wd, tv[i].wd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), {31'h0, resp_valid}, 32'h0);
      chk($sformatf("v%0d_ready", i), {31'h0, req_ready}, 32'h1);
    end
    chk("mem100_final", mem[64], 32'hCAFEBEEF);
    chk("wr_total", wr_cnt, 3);

    // Reset during RD of sh: nothing gets written, outputs clear.
    w0 = wr_cnt;
    req_valid  = 1'b1;
    is_store   = 1'b1;
    funct3     = 3'b001;
    addr       = 32'h104;
    store_data = 32'h0000FFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rdA_ready", {31'h0, req_ready}, 32'h0);
    chk("rdA_we", {31'h0, mem_we}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rdA_resp", {31'h0, resp_valid}, 32'h0);
    chk("rdA_ld", load_data, 32'h0);
    chk("rdA_mis", {31'h0, misaligned}, 32'h0);
    chk("rdA_ill", {31'h0, illegal}, 32'h0);
    chk("rdA_we2", {31'h0, mem_we}, 32'h0);
    chk("rdA_maddr", mem_addr, 32'h0);
    chk("rdA_wdata", mem_wdata, 32'h0);
    chk("rdA_ready2", {31'h0, req_ready}, 32'h1);
    // A request presented while reset is held must not be taken.
    req_valid = 1'b1;
    is_store  = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    chk("rstreq_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("rdA_resp_after", {31'h0, resp_valid}, 32'h0);
    chk("rdA_nowrite", wr_cnt - w0, 0);
    chk("rdA_mem", mem[65], 32'h11223344);

    // Reset on the edge ending WR of sb: that write lands, nothing after.
    w0 = wr_cnt;
    req_valid  = 1'b1;
    is_store   = 1'b1;
    funct3     = 3'b000;
    addr       = 32'h104;
    store_data = 32'h000000AB;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrB_we", {31'h0, mem_we}, 32'h1);
    chk("wrB_wdata", mem_wdata, 32'h112233AB);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("wrB_commit", wr_cnt - w0, 1);
    chk("wrB_mem", mem[65], 32'h112233AB);
    chk("wrB_we_off", {31'h0, mem_we}, 32'h0);
    chk("wrB_wdata_clr", mem_wdata, 32'h0);
    chk("wrB_ready", {31'h0, req_ready}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    chk("wrB_nolater", wr_cnt - w0, 1);
    chk("wrB_noresp", {31'h0, resp_valid}, 32'h0);

    // Back-to-back: sw then lw with req_valid held high.
    req_valid  = 1'b1;
    is_store   = 1'b1;
    funct3     = 3'b010;
    addr       = 32'h108;
    store_data = 32'h5A5A1234;
    @(posedge clk);
    #1;
    is_store   = 1'b0;
    store_data = 32'h0;
    chk("bb_wr_ready", {31'h0, req_ready}, 32'h0);
    chk("bb_wr_we", {31'h0, mem_we}, 32'h1);
    chk("bb_wr_data", mem_wdata, 32'h5A5A1234);
    chk("bb_wr_addr", mem_addr, 32'h108);
    @(posedge clk);
    #1;
    chk("bb_resp1_ready", {31'h0, req_ready}, 32'h0);
    chk("bb_resp1_v", {31'h0, resp_valid}, 32'h1);
    chk("bb_resp1_we", {31'h0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    chk("bb_idle_ready", {31'h0, req_ready}, 32'h1);
    chk("bb_idle_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("bb_rd_ready", {31'h0, req_ready}, 32'h0);
    chk("bb_rd_resp", {31'h0, resp_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("bb_resp2_v", {31'h0, resp_valid}, 32'h1);
    chk("bb_resp2_ld", load_data, 32'h5A5A1234);
    chk("bb_resp2_ready", {31'h0, req_ready}, 32'h0);
    chk("bb_mem", mem[66], 32'h5A5A1234);
    @(posedge clk);
    #1;
    chk("bb_end_ready", {31'h0, req_ready}, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
